// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the MEM-stage data bank.
//   - size encodings SZ_BYTE / SZ_HALF / SZ_WORD (2'b11 is always an error)
//   - mem_state_e: CLEAR (post-reset zeroing sweep) and IDLE (serving requests)
//   - mem_rsp_t: one response slot {valid, err, rdata}
//   - helpers for alignment check, store lane merge and load extraction
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } mem_rsp_t;

    // High when the access cannot be served: size 11 or a lane not aligned to the size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Overlay the low bits of the store data onto the old word in little-endian lanes.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: w[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_WORD: w = wdata;
            default: w = old_word;
        endcase
        return w;
    endfunction

    // Select the addressed lane(s) of a word and zero- or sign-extend to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        r = 32'h0000_0000;
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'h00_0000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_WORD: r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// mem_rsp_pipe: LAT-deep shift register of response slots.
//   clk     rising-edge clock
//   reset   asynchronous active-low clear; drops every response in flight
//   in_rsp  response captured into stage 1 on every edge
//   out_rsp last stage, LAT-1 shifts after capture (registered)
module mem_rsp_pipe
    import mem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  mem_rsp_t in_rsp,
    output mem_rsp_t out_rsp
);

    mem_rsp_t [LAT-1:0] stage_r;

    // Shift responses one stage per cycle; reset discards everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_r <= '0;
        end else begin
            stage_r[0] <= in_rsp;
            for (int i = 1; i < LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_rsp = stage_r[LAT-1];

endmodule

// File: rtl/mem_data_bank.sv
// mem_data_bank: word-organised 32-bit data memory for the MEM stage.
// Byte/half/word accesses on little-endian lanes, valid/ready request port,
// fixed-latency response pipeline, zeroing sweep after reset.
// Optional feature macro: MEM_TRACE_EN prints every committed store.
// Ports:
//   clk, reset (async active-low)
//   pc                          instruction PC, only used by the store trace
//   req_valid/req_ready         request handshake; ready only while IDLE
//   req_we/req_addr/req_size/req_unsigned/req_wdata   request payload
//   rsp_valid/rsp_rdata/rsp_err one response per accepted request, LAT later
//   busy                        high while the clear sweep runs
module mem_data_bank
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int LAT            = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem_r [DEPTH];
    mem_state_e        state_r;
    mem_state_e        state_nx_s;
    logic [ADDR_W-1:0] sweep_r;
    logic [ADDR_W-1:0] sweep_nx_s;
    logic              ready_r;
    logic              busy_r;

    logic              accept_s;
    logic              bad_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic [31:0]       rd_word_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_idx_s;
    logic [31:0]       wr_data_s;
    mem_rsp_t          pipe_in_s;
    mem_rsp_t          pipe_out_s;
    logic              unused_s;

    // Upper address bits only matter to the trace; the array wraps on them.
    assign unused_s   = ^{pc, req_addr[31:ADDR_W+2]};

    assign accept_s   = req_valid && ready_r;
    assign word_idx_s = req_addr[ADDR_W+1:2];
    assign bad_s      = is_misaligned(req_size, req_addr[1:0]);
    // Asynchronous read so a load sees a store committed on the previous edge.
    assign rd_word_s  = mem_r[word_idx_s];

    // Next state, single write port arbitration (sweep vs store) and response capture.
    always_comb begin
        state_nx_s = state_r;
        sweep_nx_s = sweep_r;
        wr_en_s    = 1'b0;
        wr_idx_s   = word_idx_s;
        wr_data_s  = 32'h0000_0000;
        pipe_in_s  = '0;
        case (state_r)
            CLEAR: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = sweep_r;
                wr_data_s = 32'h0000_0000;
                if (sweep_r == {ADDR_W{1'b1}}) begin
                    state_nx_s = IDLE;
                    sweep_nx_s = '0;
                end else begin
                    sweep_nx_s = sweep_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            IDLE: begin
                if (accept_s) begin
                    pipe_in_s.valid = 1'b1;
                    if (bad_s) begin
                        pipe_in_s.err = 1'b1;
                    end else if (req_we) begin
                        wr_en_s   = 1'b1;
                        wr_data_s = merge_store(rd_word_s, req_wdata, req_size, req_addr[1:0]);
                    end else begin
                        pipe_in_s.rdata = extract_load(rd_word_s, req_size, req_addr[1:0],
                                                       req_unsigned);
                    end
                end else begin
                    pipe_in_s = '0;
                end
            end
            default: begin
                state_nx_s = CLEAR_ON_RESET ? CLEAR : IDLE;
                sweep_nx_s = '0;
            end
        endcase
    end

    // FSM state, sweep index and the registered handshake/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= CLEAR_ON_RESET ? CLEAR : IDLE;
            sweep_r <= '0;
            ready_r <= 1'b0;
            busy_r  <= CLEAR_ON_RESET;
        end else begin
            state_r <= state_nx_s;
            sweep_r <= sweep_nx_s;
            ready_r <= (state_nx_s == IDLE);
            busy_r  <= (state_nx_s == CLEAR);
        end
    end

    // Storage array: contents are cleared by the sweep, never by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

`ifdef MEM_TRACE_EN
    // Trace each store as it commits, showing the full merged word.
    always @(posedge clk) begin
        if (reset && wr_en_s && (state_r == IDLE)) begin
            $display("%0t@%h: *%h <= %h", $time, pc, {req_addr[31:2], 2'b00}, wr_data_s);
        end
    end
`endif

    mem_rsp_pipe #(.LAT(LAT)) u_rsp_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_rsp  (pipe_in_s),
        .out_rsp (pipe_out_s)
    );

    assign rsp_valid = pipe_out_s.valid;
    assign rsp_err   = pipe_out_s.err;
    assign rsp_rdata = pipe_out_s.rdata;
    assign req_ready = ready_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_data_bank.sv
// Bench for mem_data_bank: two instances (LAT = 2 and LAT = 3, ADDR_W = 4)
// share one request stream. A byte-array model computes every response; one
// compare process checks both response ports every cycle against it.
module tb_mem_data_bank;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;

    logic        ready2, rvalid2, err2, busy2;
    logic [31:0] rdata2;
    logic        ready3, rvalid3, err3, busy3;
    logic [31:0] rdata3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: 64 bytes (2**4 words), plus expected responses indexed by acceptance edge.
    logic [7:0]  mbytes [64];
    bit          exp_v  [64];
    bit          exp_e  [64];
    logic [31:0] exp_d  [64];
    logic [31:0] last_exp;
    bit          last_err;

    mem_data_bank #(.ADDR_W(4), .LAT(2), .CLEAR_ON_RESET(1'b1)) dut2 (
        .clk(clk), .reset(reset), .pc(pc), .req_valid(req_valid), .req_ready(ready2),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rvalid2),
        .rsp_rdata(rdata2), .rsp_err(err2), .busy(busy2)
    );

    mem_data_bank #(.ADDR_W(4), .LAT(3), .CLEAR_ON_RESET(1'b1)) dut3 (
        .clk(clk), .reset(reset), .pc(pc), .req_valid(req_valid), .req_ready(ready3),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rvalid3),
        .rsp_rdata(rdata3), .rsp_err(err3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Issue one request, called just after a falling edge; accepted on the next rising edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata);
        int n, base, slot;
        bit bad;
        logic [31:0] v;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        pc           = $urandom;
        chk("req_ready", {ready2, ready3}, 32'd3);
        n    = nbytes(size);
        base = int'(addr[5:0]);
        bad  = (n == 0) || ((base % n) != 0);
        v    = 32'h0;
        if (!bad && we) begin
            for (int k = 0; k < n; k++) mbytes[base + k] = wdata[8*k +: 8];
        end else if (!bad) begin
            for (int k = 0; k < n; k++) v = v | (32'(mbytes[base + k]) << (8 * k));
            if (!uns && n < 4 && v[8*n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        end
        slot        = (cyc + 1) % 64;
        exp_v[slot] = 1'b1;
        exp_e[slot] = bad;
        exp_d[slot] = v;
        last_exp    = v;
        last_err    = bad;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Assert reset now, check the reset outputs, release and time the clear sweep.
    task automatic apply_reset();
        int f2, f3, r2, r3;
        reset     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_v[i]  = 1'b0;
            mbytes[i] = 8'h00;
        end
        #1;
        chk("reset_rsp_valid", {rvalid2, rvalid3}, 32'd0);
        chk("reset_rsp_err", {err2, err3}, 32'd0);
        chk("reset_rdata2", rdata2, 32'd0);
        chk("reset_rdata3", rdata3, 32'd0);
        chk("reset_busy", {busy2, busy3}, 32'd3);
        chk("reset_ready", {ready2, ready3}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        f2 = 0; f3 = 0; r2 = 0; r3 = 0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            #1;
            if (f2 == 0 && !busy2)  f2 = e;
            if (f3 == 0 && !busy3)  f3 = e;
            if (r2 == 0 && ready2)  r2 = e;
            if (r3 == 0 && ready3)  r3 = e;
        end
        chk("sweep_len_lat2", f2, 32'd16);
        chk("sweep_len_lat3", f3, 32'd16);
        chk("ready_rise_lat2", r2, 32'd16);
        chk("ready_rise_lat3", r3, 32'd16);
        @(negedge clk);
    endtask

    // Response is registered in stage LAT, reached LAT-1 edges after acceptance edge A;
    // visible in the cycle ending at edge A+LAT.
    initial begin
        int s2, s3;
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b1 && cyc >= 3) begin
                s2 = (cyc - 1) % 64;
                s3 = (cyc - 2) % 64;
                chk("rsp_valid_lat2", rvalid2, exp_v[s2]);
                if (exp_v[s2]) begin
                    chk("rsp_err_lat2", err2, exp_e[s2]);
                    chk("rsp_rdata_lat2", rdata2, exp_d[s2]);
                end
                chk("rsp_valid_lat3", rvalid3, exp_v[s3]);
                if (exp_v[s3]) begin
                    chk("rsp_err_lat3", err3, exp_e[s3]);
                    chk("rsp_rdata_lat3", rdata3, exp_d[s3]);
                end
                exp_v[s3] = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 64; i++) begin
            exp_v[i] = 1'b0;
            exp_e[i] = 1'b0;
            exp_d[i] = 32'h0;
        end
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h0; pc = 32'h0;
        #2;
        apply_reset();

        // Every word reads back zero after the sweep.
        for (int w = 0; w < 16; w++) begin
            do_req(1'b0, 32'(w * 4), 2'b10, 1'b0, 32'h0);
            chk("model_cleared_word", last_exp, 32'h0);
        end

        // Word store then signed / unsigned byte loads of the top lane.
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
        chk("model_lb_signed", last_exp, 32'hFFFFFFDE);
        do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
        chk("model_lb_unsigned", last_exp, 32'h000000DE);

        // Half store over an existing word.
        do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'hAAAAAAAA);
        do_req(1'b1, 32'h22, 2'b01, 1'b0, 32'h55661234);
        do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        chk("model_half_merge", last_exp, 32'h1234AAAA);

        // Misaligned and size-11 accesses error out and leave memory alone.
        do_req(1'b1, 32'h1, 2'b10, 1'b0, 32'hFFFFFFFF);
        chk("model_err_sw", {31'h0, last_err}, 32'd1);
        do_req(1'b0, 32'h3, 2'b01, 1'b0, 32'h0);
        chk("model_err_lh", {31'h0, last_err}, 32'd1);
        do_req(1'b0, 32'h4, 2'b11, 1'b1, 32'h0);
        chk("model_err_sz11", {31'h0, last_err}, 32'd1);
        do_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
        chk("model_unchanged", last_exp, 32'h0);

        // Address wrap, then back-to-back store/load to the same word.
        do_req(1'b1, 32'h40, 2'b10, 1'b0, 32'h11223344);
        do_req(1'b0, 32'h40 + (32'd4 << 4), 2'b10, 1'b0, 32'h0);
        chk("model_wrap", last_exp, 32'h11223344);
        do_req(1'b1, 32'h44, 2'b00, 1'b0, 32'h000000A5);
        do_req(1'b0, 32'h44, 2'b10, 1'b0, 32'h0);
        chk("model_b2b", last_exp, 32'h000000A5);
        do_req(1'b0, 32'h06, 2'b01, 1'b0, 32'h0);

        // Randomized traffic with occasional idle cycles.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(3) == 0) @(negedge clk);
            sz = 2'($urandom_range(3));
            a  = $urandom;
            if ($urandom_range(3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(1)), a, sz, 1'($urandom_range(1)), $urandom);
        end
        repeat (4) @(negedge clk);

        // Reset with two loads in flight: nothing comes out, stored data is cleared.
        do_req(1'b1, 32'h08, 2'b10, 1'b0, 32'hCAFEF00D);
        do_req(1'b0, 32'h08, 2'b10, 1'b0, 32'h0);
        do_req(1'b0, 32'h0C, 2'b10, 1'b0, 32'h0);
        apply_reset();
        do_req(1'b0, 32'h08, 2'b10, 1'b0, 32'h0);
        chk("model_after_reset", last_exp, 32'h0);
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_data_bank.md
Name: mem_data_bank

Overview:
Parametrised word-organised data memory with byte/half/word access and little-endian byte lanes. Uses a valid/ready request port and a fixed-latency response pipeline. Clears its contents with a post-reset sweep FSM instead of a single-cycle array reset. Sits in the MEM stage behind the ALU address path; every accepted request returns exactly one response LAT cycles later.

Parameters:
ADDR_W, 12, word-address width; depth = 2**ADDR_W words of 32 bits
LAT, 1, response latency in cycles from acceptance edge; legal range 1..4
CLEAR_ON_RESET, 1, 1 = run the zeroing sweep after reset; 0 = go straight to IDLE with contents undefined

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
pc  in  32  PC of the requesting instruction, used only for the trace
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as misaligned
req_unsigned  in  1  zero-extend sub-word loads when 1, sign-extend when 0
req_wdata  in  32  store data, taken from the low bits
rsp_valid  out  1  one-cycle pulse per accepted request
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned access or size = 11
busy  out  1  high while the clear sweep runs

Behaviour:
- Reset (reset = 0, asynchronous): FSM goes to CLEAR if CLEAR_ON_RESET, else IDLE. Sweep index = 0. All pipeline valid bits = 0. rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. busy = CLEAR_ON_RESET. req_ready = 0.
- CLEAR: writes 0 to word[index] each cycle and increments index. On the cycle the last word (2**ADDR_W - 1) is written, transition to IDLE. busy = 1 and req_ready = 0 throughout. Sweep takes exactly 2**ADDR_W cycles.
- IDLE: req_ready = 1. A request is accepted on a rising edge where req_valid && req_ready. No backpressure on responses.
- Word index = req_addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap.
- Alignment: half requires addr[0] = 0; word requires addr[1:0] = 00. On misalignment or size = 11: no memory write, response has rsp_err = 1 and rdata = 0.
- Store: byte lane = addr[1:0]. Byte writes wdata[7:0] to that lane; half writes wdata[15:0] to lanes {addr[1],0}; word writes all four lanes. The write commits on the acceptance edge.
- Load: the word is read combinationally at acceptance, the lane is selected, the result is extended per req_unsigned, and the value enters pipeline stage 1. The pipeline shifts every cycle, so rsp_valid/rdata/err appear LAT cycles after the acceptance edge.
- Back-to-back ordering: a load accepted the cycle after a store to the same word returns the stored data, because the write has already committed.
- Throughput: one request per cycle. Up to LAT responses are in flight.
- Reset mid-operation: in-flight responses are discarded with no rsp_valid, and the sweep restarts from index 0.
- Data written before a reset is lost when CLEAR_ON_RESET = 1.

Optional Feature:
MEM_TRACE_EN — when defined, each committed store prints "time@pc: *wordaddr <= mergedword" via $display. wordaddr is {req_addr[31:2],2'b00}, and mergedword is the full 32-bit word after the lane merge. When undefined, no display code is compiled and behaviour is otherwise identical.

Decomposition:
- Package mem_pkg holds: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, the FSM state enum (CLEAR, IDLE), and a response struct {valid, err, rdata}.
- Sub-module mem_rsp_pipe: a LAT-deep shift register of response structs with async active-low clear.
- Lane merge and extension logic stay inline as functions in mem_pkg.

Test Plan:
- Reset, ADDR_W = 4, CLEAR_ON_RESET = 1 -> busy = 1 for exactly 16 cycles, req_ready rises on cycle 17, and a load from every word returns 0.
- Word store 0xDEADBEEF @0x10, then byte loads @0x13 signed and unsigned, LAT = 2 -> rdata 0xFFFFFFDE then 0x000000DE, each rsp_valid exactly 2 cycles after acceptance.
- Half store 0x1234 @0x22 over word 0xAAAAAAAA, then word load @0x20 -> 0x1234AAAA.
- Word store @0x0001 and half load @0x0003 -> rsp_err = 1, rdata = 0, memory unchanged; size = 11 -> rsp_err = 1.
- Store @0x0000_0040 then load @0x0000_0040 + (4 << ADDR_W) -> same data (wrap). Back-to-back store/load to the same word -> new data returned.
- Assert reset with 2 loads in flight (LAT = 3) -> no rsp_valid afterwards, sweep restarts, and the earlier stored data reads back 0.
